// File: rtl/block_ram_ctrl_pkg.sv
// block_ram_ctrl_pkg
//   Shared types and helpers for block_ram_ctrl.
//   - state_t    : controller FSM state encoding
//   - byte_merge : per-lane select between an old word and new data, driven
//                  by a byte strobe. It operates on a maximum-width vector, so
//                  one function body serves any NB up to MAX_NB. Callers
//                  zero-extend their operands and truncate the result back to
//                  WIDTH. Strobe bits above NB are zero after the extension,
//                  so those lanes never take new data.
package block_ram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_READ,
        RMW_WRITE,
        ERROR
    } state_t;

    localparam int MAX_NB = 128;

    typedef logic [MAX_NB*8-1:0] word_max_t;
    typedef logic [MAX_NB-1:0]   strb_max_t;

    function automatic word_max_t byte_merge(input word_max_t old_w,
                                             input word_max_t new_w,
                                             input strb_max_t strb);
        word_max_t res;
        res = old_w;
        for (int i = 0; i < MAX_NB; i++) begin
            if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/block_ram_ctrl.sv
// block_ram_ctrl
//   Converts a byte-addressed, byte-strobed request into the word-wide
//   write and read ports of block_ram. block_ram has no byte enables, so a
//   partial store becomes an internal read-modify-write. Addresses at or
//   above SIZE get an error response and never touch the RAM. Each accepted
//   request gets exactly one one-cycle response pulse.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only in IDLE
//   req_write             1 = store, 0 = load
//   req_addr              byte address
//   req_wdata, req_wstrb  store data and byte-lane enables
//   resp_valid            one-cycle response pulse, no backpressure
//   resp_rdata            load data; 0 for stores and errors
//   resp_error            address was out of range
//   ram_write_en/_address/_data   to block_ram write port (registered)
//   ram_read_address      to block_ram read port (combinational)
//   ram_read_data         from block_ram, valid one cycle after sampling
module block_ram_ctrl
    import block_ram_ctrl_pkg::*;
#(
    parameter  int SIZE  = 1024,
    parameter  int WIDTH = 32,
    localparam int NB    = WIDTH / 8,
    localparam int AW    = $clog2(SIZE / NB)
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [NB-1:0]    req_wstrb,

    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_error,

    output logic             ram_write_en,
    output logic [AW-1:0]    ram_write_address,
    output logic [WIDTH-1:0] ram_write_data,
    output logic [AW-1:0]    ram_read_address,
    input  logic [WIDTH-1:0] ram_read_data
);

    localparam int OFF = $clog2(NB);

    // Parameter sanity: same constraints as the attached block_ram.
    if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
        $error("block_ram_ctrl: WIDTH must be a multiple of 8 and at least 8");
    end
    if (NB > MAX_NB) begin : g_too_wide
        $error("block_ram_ctrl: WIDTH exceeds byte_merge maximum");
    end
    if ((SIZE % NB) != 0 || (SIZE / NB) < 2 ||
        (1 << AW) != (SIZE / NB)) begin : g_bad_size
        $error("block_ram_ctrl: SIZE must be a power-of-two number of words, at least 2");
    end

    state_t            state;
    logic [AW-1:0]     lat_idx;
    logic [WIDTH-1:0]  lat_wdata;
    logic [NB-1:0]     lat_strb;

    logic [AW-1:0]     req_idx;
    logic              req_oor;
    logic              accept;

    // Byte-offset bits are dropped; the strobe picks the lanes.
    assign req_idx   = req_addr[AW+OFF-1:OFF];
    // Full 32-bit compare so high address bits cannot alias into the RAM.
    assign req_oor   = (req_addr >= 32'(SIZE));
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // In IDLE the RAM already samples the incoming address, so a load's data
    // (or a partial store's old word) is available in the very next cycle.
    assign ram_read_address = (state == IDLE) ? req_idx : lat_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            lat_idx           <= '0;
            lat_wdata         <= '0;
            lat_strb          <= '0;
            ram_write_en      <= 1'b0;
            ram_write_address <= '0;
            ram_write_data    <= '0;
            resp_valid        <= 1'b0;
            resp_rdata        <= '0;
            resp_error        <= 1'b0;
        end else begin
            // Pulses by default; each state raises what it needs for one cycle.
            ram_write_en <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_idx   <= req_idx;
                        lat_wdata <= req_wdata;
                        lat_strb  <= req_wstrb;
                        if (req_oor) begin
                            state <= ERROR;
                        end else if (!req_write) begin
                            state <= READ;
                        end else if (req_wstrb == '1 || req_wstrb == '0) begin
                            // Whole-word store needs no read. A zero strobe
                            // walks the same path but never enables the write,
                            // so response timing is identical.
                            state             <= WRITE;
                            ram_write_en      <= (req_wstrb != '0);
                            ram_write_address <= req_idx;
                            ram_write_data    <= req_wdata;
                        end else begin
                            state <= RMW_READ;
                        end
                    end
                end

                READ: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= ram_read_data;
                    state      <= IDLE;
                end

                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end

                RMW_READ: begin
                    // Old word arrives now; untouched lanes keep it.
                    ram_write_en      <= 1'b1;
                    ram_write_address <= lat_idx;
                    ram_write_data    <= WIDTH'(byte_merge(word_max_t'(ram_read_data),
                                                           word_max_t'(lat_wdata),
                                                           strb_max_t'(lat_strb)));
                    state             <= RMW_WRITE;
                end

                RMW_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end

                ERROR: begin
                    resp_valid <= 1'b1;
                    resp_error <= 1'b1;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_ram_ctrl.sv
// tb_block_ram_ctrl
//   Drives block_ram_ctrl against a behavioural word RAM and checks every
//   cycle of each transaction against a byte-array reference memory plus
//   the documented per-operation latencies.
module tb_block_ram_ctrl;

    localparam int SIZE  = 1024;
    localparam int WIDTH = 32;
    localparam int NB    = 4;
    localparam int AW    = 8;
    localparam int WORDS = SIZE / NB;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [31:0]      req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [NB-1:0]    req_wstrb;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_error;
    logic             ram_write_en;
    logic [AW-1:0]    ram_write_address;
    logic [WIDTH-1:0] ram_write_data;
    logic [AW-1:0]    ram_read_address;
    logic [WIDTH-1:0] ram_read_data;

    always #5 clk = ~clk;

    block_ram_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wstrb         (req_wstrb),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_error        (resp_error),
        .ram_write_en      (ram_write_en),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data)
    );

    // Stand-in for block_ram: registered read, write on the clock edge.
    logic [WIDTH-1:0] ram [WORDS];
    logic             mem_init;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
        end else if (ram_write_en) begin
            ram[ram_write_address] <= ram_write_data;
        end
        ram_read_data <= ram[ram_read_address];
    end

    // Reference: plain byte-addressed memory.
    logic [7:0] ref_b [SIZE];

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_b[widx*4+3], ref_b[widx*4+2], ref_b[widx*4+1], ref_b[widx*4]};
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Presents one request, then
    // checks every cycle up to and including the response cycle. Returns at
    // the response-cycle negedge so the next call is accepted with no bubble.
    task automatic run_req(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        int          lat, wcyc, widx;
        logic        err;
        logic [31:0] exp_rd, exp_wd;
        err    = (a >= SIZE);
        widx   = int'(a[9:2]);
        exp_rd = '0;
        exp_wd = '0;
        wcyc   = 0;
        lat    = 2;
        if (!err && !w) begin
            exp_rd = ref_word(widx);
        end else if (!err && w) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_b[widx*4+i] = d[8*i +: 8];
            exp_wd = ref_word(widx);
            if (s != 4'hF && s != 4'h0) lat = 3;
            if (s != 4'h0) wcyc = lat - 1;
        end
        chk("ready_at_present", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
            end
            chk("wr_en", {31'b0, ram_write_en}, {31'b0, (k == wcyc)});
            if (k == wcyc) begin
                chk("wr_addr", {24'b0, ram_write_address}, 32'(widx));
                chk("wr_data", ram_write_data, exp_wd);
            end
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, (k == lat)});
            chk("req_ready", {31'b0, req_ready}, {31'b0, (k == lat)});
            if (k == lat) begin
                chk("resp_error", {31'b0, resp_error}, {31'b0, err});
                chk("resp_rdata", resp_rdata, exp_rd);
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_resp", {31'b0, resp_valid}, 32'd0);
        chk("idle_wr", {31'b0, ram_write_en}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        w;
        for (int i = 0; i < WORDS; i++) begin
            d = init_word(i);
            for (int j = 0; j < 4; j++) ref_b[i*4+j] = d[8*j +: 8];
        end
        reset     = 1'b1;
        mem_init  = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h44;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
        chk("rst_wr_en", {31'b0, ram_write_en}, 32'd0);
        chk("rst_wr_addr", {24'b0, ram_write_address}, 32'd0);
        chk("rst_wr_data", ram_write_data, 32'd0);
        chk("rst_rd_addr", {24'b0, ram_read_address}, 32'h11);
        reset    = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);

        // Full store then load back
        run_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        run_req(1'b0, 32'h10, 32'h0, 4'h0);
        chk("load_deadbeef_ref", ref_word(4), 32'hDEAD_BEEF);
        // Partial store: single lane 1
        run_req(1'b1, 32'h11, 32'h0000_AA00, 4'h2);
        chk("rmw_mem4", ram[4], 32'hDEAD_AAEF);
        // Out of range load and store
        run_req(1'b0, 32'h400, 32'h0, 4'h0);
        run_req(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF);
        // Last valid byte
        run_req(1'b1, 32'h3FF, 32'h7700_0000, 4'h8);
        run_req(1'b0, 32'h3FC, 32'h0, 4'h0);

        // Store with a load held valid behind it
        begin
            int i;
            i = 0;
            for (int j = 0; j < 4; j++) ref_b[32+j] = 8'(32'h1234_5678 >> (8*j));
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
            req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
            @(negedge clk);                       // T+1
            req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
            chk("hold_ready_t1", {31'b0, req_ready}, 32'd0);
            chk("hold_wr_en_t1", {31'b0, ram_write_en}, 32'd1);
            chk("hold_wr_addr_t1", {24'b0, ram_write_address}, 32'd8);
            @(negedge clk);                       // T+2, load accepted here
            chk("hold_resp_t2", {31'b0, resp_valid}, 32'd1);
            chk("hold_ready_t2", {31'b0, req_ready}, 32'd1);
            @(negedge clk);                       // T+3
            req_valid = 1'b0;
            chk("hold_resp_t3", {31'b0, resp_valid}, 32'd0);
            chk("hold_ready_t3", {31'b0, req_ready}, 32'd0);
            @(negedge clk);                       // T+4
            chk("hold_resp_t4", {31'b0, resp_valid}, 32'd1);
            chk("hold_rdata_t4", resp_rdata, ref_word(8));
            i++;
        end

        // Reset during RMW_READ drops the store
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
        req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'h3;
        @(negedge clk);                           // RMW_READ cycle
        req_valid = 1'b0;
        chk("rstmid_ready", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_wr_en", {31'b0, ram_write_en}, 32'd0);
        chk("rstmid_resp", {31'b0, resp_valid}, 32'd0);
        chk("rstmid_ready_after", {31'b0, req_ready}, 32'd1);
        reset = 1'b0;
        repeat (3) idle_cycle();
        run_req(1'b0, 32'h30, 32'h0, 4'h0);

        // Zero-strobe store leaves mem[2] alone
        run_req(1'b1, 32'h8, 32'hCAFE_F00D, 4'h0);
        chk("zstrb_mem2", ram[2], ref_word(2));
        run_req(1'b0, 32'h8, 32'h0, 4'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 85)      a = 32'($urandom_range(0, SIZE - 1));
            else if (r < 95) a = 32'($urandom_range(SIZE, SIZE + 255));
            else             a = $urandom | 32'h8000_0000;
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            r = $urandom_range(0, 3);
            s = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom);
            run_req(w, a, d, s);
            r = $urandom_range(0, 2);
            for (int g = 0; g < int'(r); g++) idle_cycle();
        end

        // Final sweep: model RAM must match reference
        for (int i = 0; i < WORDS; i += 17) chk("final_mem", ram[i], ref_word(i));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
